// File: rtl/shift_rows_pipe.sv
// AES ShiftRows / InvShiftRows permutation followed by an elastic register pipeline.
// The permutation is purely combinational; the pipeline stages carry data, tag and valid.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2:0]        occupancy,
  output logic              mode_err
);

  localparam int W = 32 * NB;

  // Row offsets; the 256-bit state uses the wider spacing on rows 2 and 3.
  function automatic int row_shift(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  logic [W-1:0] perm;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH  = row_shift(r);
      localparam int FWD = (c + SH) % NB;
      localparam int INV = (c - SH + NB) % NB;
      localparam int DST = W - 1 - 32 * c - 8 * r;
      localparam int SF  = W - 1 - 32 * FWD - 8 * r;
      localparam int SI  = W - 1 - 32 * INV - 8 * r;
      assign perm[DST -: 8] = (in_mode == 2'b00) ? in_data[SF -: 8] :
                              (in_mode == 2'b01) ? in_data[SI -: 8] :
                                                   in_data[DST -: 8];
    end
  end

  logic             vld   [STAGES];
  logic [W-1:0]     sdata [STAGES];
  logic [TAG_W-1:0] stag  [STAGES];
  logic [STAGES-1:0] rdy;

  // rdy[k]: stage k can load this cycle (empty, or its content moves on).
  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain  = !vld[k] || chain;
      rdy[k] = chain;
    end
  end

  logic in_xfer;
  logic out_xfer;

  assign in_ready  = rdy[0] && !rst;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = vld[STAGES-1];
  assign out_data  = sdata[STAGES-1];
  assign out_tag   = stag[STAGES-1];
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k]   <= 1'b0;
        sdata[k] <= '0;
        stag[k]  <= '0;
      end
      occupancy <= '0;
      mode_err  <= 1'b0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          sdata[0] <= perm;
          stag[0]  <= in_tag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            sdata[k] <= sdata[k-1];
            stag[k]  <= stag[k-1];
          end
        end
      end
      case ({in_xfer, out_xfer})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
      if (in_xfer && in_mode == 2'b11)
        mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench: NB=4/1-stage vector table, NB=8/2-stage streaming with backpressure,
// and a 3-stage instance for full-pipeline and mid-flight reset behaviour.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: NB=4, STAGES=1
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_in_mode;
  logic [3:0]   a_in_tag, a_out_tag;
  logic [2:0]   a_occ;

  // Instance b: NB=8, STAGES=2
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [255:0] b_in_data, b_out_data;
  logic [1:0]   b_in_mode;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [2:0]   b_occ;

  // Instance c: NB=4, STAGES=3
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_err;
  logic [127:0] c_in_data, c_out_data;
  logic [1:0]   c_in_mode;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [2:0]   c_occ;

  shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .occupancy(a_occ), .mode_err(a_err));

  shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .occupancy(b_occ), .mode_err(b_err));

  shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_tag(c_out_tag), .occupancy(c_occ), .mode_err(c_err));

  localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] SEQ_IN   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] SEQ_FWD  = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] SEQ_INV  = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [255:0] NB8_IN   = 256'h00081018_01091119_020a121a_030b131b_040c141c_050d151d_060e161e_070f171f;
  localparam logic [255:0] NB8_FWD  = 256'h0009131c_010a141d_020b151e_030c161f_040d1718_050e1019_060f111a_0708121b;
  localparam logic [255:0] NB8_INV  = 256'h000f151c_0108161d_0209171e_030a101f_040b1118_050c1219_060d131a_070e141b;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] din;
    logic [3:0]   tag;
    logic [127:0] dexp;
    logic         err;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One transfer into instance a, then junk on the idle inputs.
  task automatic applyStimulus(input vec_t v);
    a_in_valid = 1'b1;
    a_in_mode  = v.mode;
    a_in_data  = v.din;
    a_in_tag   = v.tag;
    tick();
    a_in_valid = 1'b0;
    a_in_mode  = 2'b11;
    a_in_data  = '1;
    a_in_tag   = '1;
  endtask

  initial begin
    int         next_tag;
    int         occ_model;
    int         got;
    logic       in_x, out_x, prev_stall;
    logic [3:0] prev_tag, nt, exp_tag;

    vecs[0] = '{2'b00, FIPS_IN,  4'h1, FIPS_OUT, 1'b0};
    vecs[1] = '{2'b01, FIPS_OUT, 4'h2, FIPS_IN,  1'b0};
    vecs[2] = '{2'b10, FIPS_IN,  4'h3, FIPS_IN,  1'b0};
    vecs[3] = '{2'b10, FIPS_OUT, 4'h4, FIPS_OUT, 1'b0};
    vecs[4] = '{2'b00, SEQ_IN,   4'h6, SEQ_FWD,  1'b0};
    vecs[5] = '{2'b01, SEQ_IN,   4'h7, SEQ_INV,  1'b0};
    vecs[6] = '{2'b11, FIPS_IN,  4'h5, FIPS_IN,  1'b1};
    vecs[7] = '{2'b00, SEQ_IN,   4'h9, SEQ_FWD,  1'b1};

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 2'b00; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'b00; b_in_tag = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_mode = 2'b00; c_in_tag = '0; c_out_ready = 1'b1;

    // Reset state
    tick(); tick();
    checkOutput("rst_out_valid", a_out_valid, 0);
    checkOutput("rst_occ",       a_occ, 0);
    checkOutput("rst_mode_err",  a_err, 0);
    checkOutput("rst_out_data",  a_out_data, 0);
    checkOutput("rst_in_ready",  a_in_ready, 0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", a_in_ready, 1);

    // Idle cycle with mode 11 on the bus but no valid must not set mode_err
    a_in_mode = 2'b11;
    tick();
    checkOutput("idle_mode_ignored", a_err, 0);
    checkOutput("idle_no_output", a_out_valid, 0);

    // Table of single-state transfers through the 1-stage instance
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_valid", i), a_out_valid, 1);
      checkOutput($sformatf("vec%0d_data", i),  a_out_data, vecs[i].dexp);
      checkOutput($sformatf("vec%0d_tag", i),   a_out_tag, vecs[i].tag);
      checkOutput($sformatf("vec%0d_err", i),   a_err, vecs[i].err);
      checkOutput($sformatf("vec%0d_occ", i),   a_occ, 1);
      tick();
      checkOutput($sformatf("vec%0d_drain", i), a_out_valid, 0);
      checkOutput($sformatf("vec%0d_occ0", i),  a_occ, 0);
    end

    // Backpressure hold on the 1-stage instance
    a_out_ready = 1'b0;
    applyStimulus(vecs[4]);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_data", a_out_data, SEQ_FWD);
      checkOutput("hold_tag",  a_out_tag, 4'h6);
      checkOutput("hold_full_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1;
    checkOutput("full_advance_in_ready", a_in_ready, 1);
    tick();
    checkOutput("hold_release", a_out_valid, 0);
    checkOutput("err_sticky", a_err, 1);

    // Latency of the 2-stage NB=8 instance, forward then inverse
    b_in_valid = 1'b1; b_in_mode = 2'b00; b_in_data = NB8_IN; b_in_tag = 4'h7;
    tick();
    b_in_valid = 1'b0;
    checkOutput("b_lat_early", b_out_valid, 0);
    checkOutput("b_lat_occ",   b_occ, 1);
    tick();
    checkOutput("b_fwd_valid", b_out_valid, 1);
    checkOutput("b_fwd_data",  b_out_data, NB8_FWD);
    checkOutput("b_fwd_col0",  b_out_data[255:224], 32'h0009131c);
    checkOutput("b_fwd_col7",  b_out_data[31:0], 32'h0708121b);
    checkOutput("b_fwd_tag",   b_out_tag, 4'h7);
    b_in_valid = 1'b1; b_in_mode = 2'b01; b_in_data = NB8_IN; b_in_tag = 4'h8;
    tick();
    b_in_valid = 1'b0;
    tick();
    checkOutput("b_inv_data", b_out_data, NB8_INV);
    checkOutput("b_inv_tag",  b_out_tag, 4'h8);
    tick();
    checkOutput("b_idle", b_out_valid, 0);

    // Streaming tags 1..6 with out_ready low for cycles 3-5
    next_tag = 1; occ_model = 0; got = 0; prev_stall = 1'b0; prev_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      nt = 4'(next_tag);
      b_out_ready = !(cyc >= 3 && cyc <= 5);
      b_in_valid  = (next_tag <= 6);
      b_in_mode   = 2'b10;
      b_in_tag    = nt;
      b_in_data   = {64{nt}};
      #1;
      checkOutput("stream_occ", b_occ, 3'(occ_model));
      checkOutput("stream_occ_max", (b_occ <= 3'd2), 1);
      checkOutput("stream_in_ready", b_in_ready, !(occ_model == 2 && !b_out_ready));
      if (prev_stall)
        checkOutput("stream_hold_tag", b_out_tag, prev_tag);
      in_x  = b_in_valid && b_in_ready;
      out_x = b_out_valid && b_out_ready;
      if (out_x) begin
        exp_tag = 4'(got + 1);
        checkOutput("stream_tag",  b_out_tag, exp_tag);
        checkOutput("stream_data", b_out_data, {64{exp_tag}});
        got++;
      end
      prev_stall = b_out_valid && !b_out_ready;
      prev_tag   = b_out_tag;
      occ_model  = occ_model + int'(in_x) - int'(out_x);
      if (in_x) next_tag++;
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    checkOutput("stream_count", got, 6);

    // Fill the 3-stage instance, then push and pop together while full
    c_out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      c_in_valid = 1'b1; c_in_mode = 2'b00; c_in_data = SEQ_IN; c_in_tag = 4'(t);
      tick();
    end
    c_in_valid = 1'b0;
    checkOutput("c_full_occ",      c_occ, 3);
    checkOutput("c_full_in_ready", c_in_ready, 0);
    checkOutput("c_full_tag",      c_out_tag, 4'h1);
    checkOutput("c_full_data",     c_out_data, SEQ_FWD);
    c_out_ready = 1'b1;
    c_in_valid = 1'b1; c_in_tag = 4'h4;
    #1;
    checkOutput("c_both_in_ready", c_in_ready, 1);
    tick();
    c_in_valid = 1'b0;
    c_out_ready = 1'b0;
    checkOutput("c_both_occ", c_occ, 3);
    checkOutput("c_both_tag", c_out_tag, 4'h2);

    // Mid-flight reset discards everything
    rst = 1'b1;
    tick();
    checkOutput("c_rst_occ",      c_occ, 0);
    checkOutput("c_rst_valid",    c_out_valid, 0);
    checkOutput("c_rst_data",     c_out_data, 0);
    checkOutput("c_rst_tag",      c_out_tag, 0);
    checkOutput("c_rst_in_ready", c_in_ready, 0);
    checkOutput("a_rst_err",      a_err, 0);
    rst = 1'b0;
    c_out_ready = 1'b1;
    tick();
    checkOutput("c_post_rst_in_ready", c_in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("c_no_stale", c_out_valid, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (32-bit words); legal values 4, 6, 8.
REQ-002 SHALL have parameter STAGES, default 1, meaning pipeline register depth; legal values 1..4.
REQ-003 SHALL have parameter TAG_W, default 4, meaning sideband tag width carried with each state.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input state valid.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_data  in  32*NB  input state; column 0 in MSBs; within a column, row 0 in MSB byte (FIPS-197 order).
REQ-009 in_mode  in  2  00 forward ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved.
REQ-010 in_tag  in  TAG_W  opaque sideband, passed through unchanged.
REQ-011 out_valid  out  1  output state valid.
REQ-012 out_ready  in  1  downstream accepts output.
REQ-013 out_data  out  32*NB  transformed state.
REQ-014 out_tag  out  TAG_W  tag of the state on out_data.
REQ-015 occupancy  out  3  number of valid stage registers, 0..STAGES.
REQ-016 mode_err  out  1  sticky flag: a mode-11 transfer was accepted.

Function
REQ-017 Row shift offsets C_r SHALL be (0,1,2,3) for NB=4 and NB=6, and (0,1,3,4) for NB=8.
REQ-018 Forward: out byte[c][r] SHALL equal in byte[(c+C_r) mod NB][r].
REQ-019 Inverse: out byte[c][r] SHALL equal in byte[(c-C_r+NB) mod NB][r].
REQ-020 Bypass and reserved modes SHALL pass in_data unchanged.
REQ-021 The permutation SHALL be combinational ahead of stage 0; stages 1..STAGES-1 SHALL be pure registers; out_data, out_tag and out_valid SHALL be driven directly from the last stage register.
REQ-022 A transfer SHALL occur on an edge where valid and ready are both high, on either port.
REQ-023 Stage k SHALL load from stage k-1 (stage 0 from input) when stage k is empty or stage k is advancing in the same cycle; no bubbles SHALL be inserted.
REQ-024 in_ready SHALL be high when stage 0 is empty or stage 0 advances this cycle; combinational depth from out_ready to in_ready is permitted.
REQ-025 Latency SHALL be STAGES cycles from input transfer to out_valid, with out_ready held high.
REQ-026 Throughput SHALL be one state per cycle with out_ready held high.
REQ-027 Order SHALL be preserved; no accepted state SHALL be dropped or duplicated under any out_ready pattern.
REQ-028 While out_valid is high and out_ready low, out_data and out_tag SHALL hold stable.
REQ-029 Full condition: with all STAGES valid and out_ready low, in_ready SHALL be low.
REQ-030 Simultaneous input and output transfers when full SHALL keep occupancy at STAGES.
REQ-031 occupancy SHALL increment on input-only transfers, decrement on output-only transfers, and hold on both or neither.
REQ-032 mode_err SHALL set on the cycle after an accepted mode-11 transfer and clear only on rst.
REQ-033 in_mode is sampled only on transfer; in_* values on non-transfer cycles SHALL have no effect.

Reset
REQ-034 While rst is high at an edge, all stage valid bits, occupancy and mode_err SHALL become 0, and out_data and out_tag SHALL become 0.
REQ-035 During rst, in_ready SHALL be driven low; the cycle after rst deasserts, in_ready SHALL be high.
REQ-036 rst mid-operation SHALL discard all in-flight states; none SHALL appear on the output afterwards.

Verification
REQ-037 NB=4, STAGES=1, mode 00, in_data=d42711ae_e0bf98f1_b8b45de5_1e415230 -> one cycle later out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
REQ-038 Same configuration, mode 01, in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_data=d42711ae_e0bf98f1_b8b45de5_1e415230; mode 10 on either value -> data unchanged.
REQ-039 NB=8, mode 00, column c bytes {c,8+c,16+c,24+c} -> column 0 out = {00,09,13,1c}, column 7 out = {07,08,12,1b}.
REQ-040 STAGES=2, stream tags 1..6 back-to-back, out_ready low for cycles 3-5 -> in_ready low while occupancy=2; tags emerge 1..6 in order with no loss; occupancy never exceeds 2.
REQ-041 STAGES=3, three states in flight, rst pulsed for one cycle -> occupancy=0, out_valid=0, out_data=0 the next cycle; no pre-reset tag ever appears on the output.
REQ-042 Mode-11 transfer with tag 5 -> data passes unchanged with out_tag=5; mode_err=1 and stays 1 until rst.
